ex_issue: RTL and testbench

EX_ISSUE -- requirements
Module: ex_issue

---
 rtl/ex_issue.sv | 121 ++++++++++++
 tb/tb_ex_issue.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_issue.sv
// Single-slot issue stage: registers one operation onto the ALU, holds it for
// its EXEC cycles and presents the result. Optional forwarding: EX_ISSUE_FWD_EN.
module ex_issue #(
    parameter int MUL_CYCLES = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_opcode,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        in_fwd_a,
    input  logic        in_fwd_b,
    output logic [1:0]  alu_opcode,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_err
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;
    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic        accept, complete, hs;
    logic [31:0] opnd_a, opnd_b;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_nxt = EXEC;
                EXEC:    if (cnt == 4'd0) state_nxt = DONE;
                DONE:    if (out_ready) state_nxt = accept ? EXEC : IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready = ((state == IDLE) || ((state == DONE) && out_ready)) && !flush;
        accept   = in_valid && in_ready;
        complete = (state == EXEC) && (cnt == 4'd0) && !flush;
        hs       = out_valid && out_ready && !flush;
    end

`ifdef EX_ISSUE_FWD_EN
    logic [31:0] fwd, fwd_src;

    // A handshake in the accept cycle forwards the result completing right now.
    assign fwd_src = hs ? out_result : fwd;

    always_comb begin
        opnd_a = in_fwd_a ? fwd_src : in_a;
        opnd_b = in_fwd_b ? fwd_src : in_b;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)   fwd <= '0;
        else if (hs) fwd <= out_result;
    end
`else
    logic unused_fwd;
    assign unused_fwd = in_fwd_a ^ in_fwd_b;

    always_comb begin
        opnd_a = in_a;
        opnd_b = in_b;
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            alu_opcode <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_err    <= 1'b0;
        end else begin
            if (accept) begin
                alu_opcode <= in_opcode;
                alu_a      <= opnd_a;
                alu_b      <= opnd_b;
                cnt        <= (in_opcode == OP_MUL) ? MUL_LOAD : 4'd0;
            end else if ((state == EXEC) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end

            // Flush outranks completion; a completed output drops on handshake.
            if (flush) begin
                out_valid <= 1'b0;
                out_err   <= 1'b0;
            end else if (complete) begin
                out_valid  <= 1'b1;
                out_result <= (alu_opcode == OP_RSV) ? 32'd0 : alu_result;
                out_err    <= (alu_opcode == OP_RSV);
            end else if (hs) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ex_issue.sv
// Directed and randomized bench for ex_issue; plays the role of the ALU and
// checks every result against an arithmetic reference model.
module tb_ex_issue;

    localparam int MUL_CYCLES = 3;
`ifdef EX_ISSUE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_opcode;
    logic [31:0] in_a, in_b;
    logic        in_fwd_a, in_fwd_b;
    logic [1:0]  alu_opcode;
    logic [31:0] alu_a, alu_b;
    logic [31:0] alu_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_err;

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] last_hs;

    ex_issue #(.MUL_CYCLES(MUL_CYCLES)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_a(in_a), .in_b(in_b), .in_fwd_a(in_fwd_a), .in_fwd_b(in_fwd_b),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_err(out_err)
    );

    always #5 clock = ~clock;

    // Stand-in ALU; the reserved opcode returns junk the DUT must suppress.
    always_comb begin
        case (alu_opcode)
            2'b00:   alu_result = alu_a + alu_b;
            2'b01:   alu_result = alu_a - alu_b;
            2'b10:   alu_result = alu_a * alu_b;
            default: alu_result = 32'hDEAD_BEEF;
        endcase
    end

    function automatic logic [31:0] model_result(input logic [1:0] op, input logic [31:0] a, b);
        if (op == 2'b00) return a + b;
        if (op == 2'b01) return a - b;
        if (op == 2'b10) return a * b;
        return 32'd0;
    endfunction

    function automatic int model_latency(input logic [1:0] op);
        return (op == 2'b10) ? MUL_CYCLES + 1 : 2;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic noise();
        in_valid  = 1'($urandom);
        in_opcode = 2'($urandom);
        in_a      = $urandom;
        in_b      = $urandom;
        in_fwd_a  = 1'($urandom);
        in_fwd_b  = 1'($urandom);
    endtask

    // One complete transaction: accept, EXEC, optional output stall, handshake.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic fa, input logic fb, input int stall);
        logic [31:0] ea, eb, er;
        int lat;
        ea = (FWD && fa) ? last_hs : a;
        eb = (FWD && fb) ? last_hs : b;
        er = model_result(op, ea, eb);
        for (int i = 0; i < 20 && !in_ready; i++) tick();
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_opcode = op; in_a = a; in_b = b;
        in_fwd_a = fa; in_fwd_b = fb; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        check("alu_opcode", 32'(alu_opcode), 32'(op));
        check("alu_a", alu_a, ea);
        check("alu_b", alu_b, eb);
        lat = 1;
        for (int i = 0; i < 20; i++) begin
            noise();
            tick();
            lat++;
            if (out_valid) break;
            check("exec_alu_a", alu_a, ea);
            check("exec_alu_b", alu_b, eb);
            check("exec_in_ready", 32'(in_ready), 32'd0);
        end
        check("latency", 32'(lat), 32'(model_latency(op)));
        check("out_result", out_result, er);
        check("out_err", 32'(out_err), 32'(op == 2'b11));
        for (int i = 0; i < stall; i++) begin
            noise();
            tick();
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_result", out_result, er);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_alu_a", alu_a, ea);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        check("done_in_ready", 32'(in_ready), 32'd1);
        tick();
        last_hs = er;
        out_ready = 1'b0;
        check("post_hs_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_opcode = 2'b00;
        in_a = '0; in_b = '0; in_fwd_a = 1'b0; in_fwd_b = 1'b0; out_ready = 1'b0;
        last_hs = '0;
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_alu_opcode", 32'(alu_opcode), 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_b", alu_b, 32'd0);
        reset = 1'b0;
        tick();

        // Basic ADD, MUL, stalled SUB, reserved opcode
        run_op(2'b00, 32'd5, 32'd7, 1'b0, 1'b0, 0);
        run_op(2'b10, 32'h0001_0000, 32'h10, 1'b0, 1'b0, 0);
        run_op(2'b01, 32'd3, 32'd5, 1'b0, 1'b0, 5);
        run_op(2'b11, 32'd9, 32'd4, 1'b0, 1'b0, 0);

        // Back-to-back: second ADD accepted in the first one's handshake cycle
        in_valid = 1'b1; in_opcode = 2'b00; in_a = 32'd1; in_b = 32'd1;
        in_fwd_a = 1'b0; in_fwd_b = 1'b0; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("b2b_first_valid", 32'(out_valid), 32'd1);
        check("b2b_first_result", out_result, 32'd2);
        in_valid = 1'b1; in_opcode = 2'b00; in_a = 32'd100; in_b = 32'd3; in_fwd_a = 1'b1;
        #1;
        check("b2b_no_bubble", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0; in_fwd_a = 1'b0;
        last_hs = 32'd2;
        check("b2b_alu_a", alu_a, FWD ? 32'd2 : 32'd100);
        check("b2b_gap_valid", 32'(out_valid), 32'd0);
        tick();
        check("b2b_second_valid", 32'(out_valid), 32'd1);
        check("b2b_second_result", out_result, FWD ? 32'd5 : 32'd103);
        tick();
        last_hs = FWD ? 32'd5 : 32'd103;
        out_ready = 1'b0;
        check("b2b_drain", 32'(out_valid), 32'd0);

        // Flush during MUL EXEC
        in_valid = 1'b1; in_opcode = 2'b10; in_a = 32'd6; in_b = 32'd7;
        tick();
        in_valid = 1'b0;
        tick();
        flush = 1'b1;
        #1;
        check("flush_in_ready", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < MUL_CYCLES + 2; i++) begin
            check("flush_no_output", 32'(out_valid), 32'd0);
            tick();
        end
        out_ready = 1'b0;
        run_op(2'b00, 32'd5, 32'd7, 1'b0, 1'b0, 0);

        // Reset asynchronously during MUL EXEC
        in_valid = 1'b1; in_opcode = 2'b10; in_a = 32'd11; in_b = 32'd13;
        tick();
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("arst_alu_a", alu_a, 32'd0);
        check("arst_alu_opcode", 32'(alu_opcode), 32'd0);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        tick();
        reset = 1'b0;
        last_hs = 32'd0;
        out_ready = 1'b1;
        #1;
        check("arst_no_output", 32'(out_valid), 32'd0);
        out_ready = 1'b0;
        run_op(2'b00, 32'd5, 32'd7, 1'b0, 1'b0, 0);

        // Randomized transactions
        for (int k = 0; k < 24; k++) begin
            run_op(2'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
